// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 read master.
package spi_pkg;

  localparam int   SPI_BITS    = 8;
  localparam logic SPI_CS_IDLE = 1'b1;
  localparam int   SPI_BIT_W   = $clog2(SPI_BITS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } spi_state_e;

  // A phase of N cycles counts N-1 down to 0.
  function automatic logic [7:0] div_load(input int div);
    return 8'(div - 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: tick is high in the last cycle of each CLK_DIV-long phase.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam logic [7:0] LOAD = div_load(CLK_DIV);

  logic [7:0] cnt_r;

  // Down-counter restarted on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= LOAD;
    end else if (reload) begin
      cnt_r <= LOAD;
    end else if (cnt_r != 8'd0) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= LOAD;
    end
  end

  assign tick = (cnt_r == 8'd0);

endmodule

// File: rtl/spi_master_rx.sv
// SPI mode-0 master: clocks command bytes out on mosi and returns bytes read from miso.
module spi_master_rx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] num_bytes,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [SPI_BIT_W-1:0] BIT_LAST = SPI_BIT_W'(SPI_BITS - 1);
  localparam logic [SPI_BIT_W-1:0] BIT_ONE  = SPI_BIT_W'(1);

  spi_state_e           state_r, state_nxt;
  logic [7:0]           tx_r, tx_nxt;
  logic [7:0]           rx_sr_r, rx_sr_nxt;
  logic [SPI_BIT_W-1:0] bit_r, bit_nxt;
  logic [7:0]           byte_r, byte_nxt;
  logic [7:0]           rx_data_r, rx_data_nxt;
  logic                 rx_valid_nxt;
  logic                 done_r, done_nxt;
  logic                 busy_r, busy_nxt;
  logic                 rx_valid_r;
  logic                 cs_r, sclk_r, mosi_r;
  logic                 tick_s, reload_s;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .reload(reload_s),
    .tick  (tick_s)
  );

  // Held in reload while idle so the first LOW phase is a full CLK_DIV long.
  assign reload_s = (state_r == ST_IDLE) || (state_nxt != state_r);

  // Next-state, shift register and counter logic.
  always_comb begin
    state_nxt    = state_r;
    tx_nxt       = tx_r;
    rx_sr_nxt    = rx_sr_r;
    bit_nxt      = bit_r;
    byte_nxt     = byte_r;
    rx_data_nxt  = rx_data_r;
    rx_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = busy_r;
    case (state_r)
      ST_IDLE: begin
        // The done cycle is still IDLE, but a new start is only taken one cycle later.
        if (start && !done_r) begin
          state_nxt = ST_LOW;
          tx_nxt    = tx_byte;
          byte_nxt  = num_bytes;
          bit_nxt   = '0;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (tick_s) begin
          state_nxt = ST_HIGH;
          rx_sr_nxt = {rx_sr_r[SPI_BITS-2:0], miso};
        end else begin
          state_nxt = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (tick_s) begin
          tx_nxt  = {tx_r[SPI_BITS-2:0], 1'b0};
          bit_nxt = bit_r + BIT_ONE;
          if (bit_r == BIT_LAST) begin
            rx_data_nxt  = rx_sr_r;
            rx_valid_nxt = 1'b1;
            byte_nxt     = byte_r - 8'd1;
            // A count loaded as 0 wraps to 255 here, giving 256 bytes.
            if (byte_r != 8'd1) begin
              tx_nxt    = tx_byte;
              state_nxt = ST_LOW;
            end else begin
              state_nxt = ST_HOLD;
            end
          end else begin
            state_nxt = ST_LOW;
          end
        end else begin
          state_nxt = ST_HIGH;
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          state_nxt = ST_GAP;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = ST_GAP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and pin registers; pins are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tx_r       <= 8'h00;
      rx_sr_r    <= 8'h00;
      bit_r      <= '0;
      byte_r     <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      cs_r       <= SPI_CS_IDLE;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      tx_r       <= tx_nxt;
      rx_sr_r    <= rx_sr_nxt;
      bit_r      <= bit_nxt;
      byte_r     <= byte_nxt;
      rx_data_r  <= rx_data_nxt;
      rx_valid_r <= rx_valid_nxt;
      done_r     <= done_nxt;
      busy_r     <= busy_nxt;
      cs_r       <= ((state_nxt == ST_IDLE) || (state_nxt == ST_GAP)) ? SPI_CS_IDLE : ~SPI_CS_IDLE;
      sclk_r     <= (state_nxt == ST_HIGH);
      mosi_r     <= ((state_nxt == ST_LOW) || (state_nxt == ST_HIGH)) ? tx_nxt[SPI_BITS-1] : 1'b0;
    end
  end

  assign busy     = busy_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign done     = done_r;
  assign sclk     = sclk_r;
  assign cs       = cs_r;
  assign mosi     = mosi_r;

endmodule

// File: tb/tb_spi_master_rx.sv
// Directed bench for spi_master_rx: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1.
module tb_spi_master_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start, busy, rx_valid, done, sclk, cs, mosi, miso;
  logic [7:0] num_bytes [2];
  logic [7:0] tx_byte   [2];
  logic [7:0] rx_data   [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel = 0;

  spi_master_rx #(.CLK_DIV(2)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .num_bytes(num_bytes[0]), .tx_byte(tx_byte[0]),
    .busy(busy[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .done(done[0]),
    .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master_rx #(.CLK_DIV(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .num_bytes(num_bytes[1]), .tx_byte(tx_byte[1]),
    .busy(busy[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .done(done[1]),
    .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: presents the next bit MSB-first while sclk is low.
  logic [7:0] sq[$];
  logic [7:0] s_cur = 8'h00;
  int         s_idx = 0;
  bit         s_loaded = 1'b0;
  logic       s_sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (cs[sel] !== 1'b0) begin
      s_idx = 0;
      s_loaded = 1'b0;
    end else if (!s_loaded) begin
      s_cur = 8'h00;
      if (sq.size() > 0) s_cur = sq.pop_front();
      s_loaded = 1'b1;
    end else if (sclk[sel] && !s_sclk_prev) begin
      s_idx++;
      if (s_idx == 8) begin
        s_idx = 0;
        s_cur = 8'h00;
        if (sq.size() > 0) s_cur = sq.pop_front();
      end
    end
    s_sclk_prev = sclk[sel];
    miso = 2'b00;
    miso[sel] = (cs[sel] === 1'b0) ? s_cur[7-s_idx] : 1'b0;
  end

  // Monitor of the selected instance.
  int         rx_cyc[$];
  logic [7:0] rx_dat[$];
  int         done_cyc[$];
  int         cs_rise[$];
  int         cs_fall[$];
  int         busy_rise[$];
  logic       mosi_seq[$];
  int         mosi_unstable = 0;
  int         mosi_high = 0;
  logic       m_cs_prev = 1'b1, m_busy_prev = 1'b0, m_sclk_prev = 1'b0, mosi_at_rise = 1'b0;

  always @(negedge clk) begin
    if (rx_valid[sel] === 1'b1) begin
      rx_cyc.push_back(cyc);
      rx_dat.push_back(rx_data[sel]);
    end
    if (done[sel] === 1'b1) done_cyc.push_back(cyc);
    if (cs[sel] === 1'b1 && m_cs_prev === 1'b0) cs_rise.push_back(cyc);
    if (cs[sel] === 1'b0 && m_cs_prev === 1'b1) cs_fall.push_back(cyc);
    if (busy[sel] === 1'b1 && m_busy_prev === 1'b0) busy_rise.push_back(cyc);
    if (sclk[sel] === 1'b1 && m_sclk_prev === 1'b0) begin
      mosi_seq.push_back(mosi[sel]);
      mosi_at_rise = mosi[sel];
    end else if (sclk[sel] === 1'b1 && mosi[sel] !== mosi_at_rise) begin
      mosi_unstable++;
    end
    if (cs[sel] === 1'b0 && mosi[sel] === 1'b1) mosi_high++;
    m_cs_prev   = cs[sel];
    m_busy_prev = busy[sel];
    m_sclk_prev = sclk[sel];
  end

  function automatic int first_of(input int q[$]);
    if (q.size() == 0) return -1;
    return q[0];
  endfunction

  task automatic clear_mon();
    rx_cyc.delete(); rx_dat.delete(); done_cyc.delete();
    cs_rise.delete(); cs_fall.delete(); busy_rise.delete(); mosi_seq.delete();
    mosi_unstable = 0;
    mosi_high = 0;
  endtask

  task automatic start_txn(input int idx, input logic [7:0] nb, input logic [7:0] tx, output int t);
    @(negedge clk);
    clear_mon();
    start[idx] = 1'b1;
    num_bytes[idx] = nb;
    tx_byte[idx] = tx;
    t = cyc;
    @(negedge clk);
    start[idx] = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cs !== 2'b11) begin failures++; $display("FAIL reset_cs got=%b exp=11", cs); end
    checks++; if (sclk !== 2'b00) begin failures++; $display("FAIL reset_sclk got=%b exp=00", sclk); end
    checks++; if (mosi !== 2'b00) begin failures++; $display("FAIL reset_mosi got=%b exp=00", mosi); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", busy); end
    checks++; if (rx_valid !== 2'b00 || done !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b/%b exp=00/00", rx_valid, done);
    end
    checks++; if (rx_data[0] !== 8'h00 || rx_data[1] !== 8'h00) begin
      failures++; $display("FAIL reset_rx_data got=%h/%h exp=00/00", rx_data[0], rx_data[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cs !== 2'b11 || busy !== 2'b00) begin
      failures++; $display("FAIL idle_after_reset got=cs%b busy%b exp=cs11 busy00", cs, busy);
    end
  endtask

  task automatic test_single();
    int t;
    sel = 0; sq.delete(); sq.push_back(8'hA5);
    start_txn(0, 8'd1, 8'h00, t);
    repeat (45) @(negedge clk);
    #1;
    checks++; if (rx_cyc.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", rx_cyc.size()); end
    checks++; if (rx_dat.size() < 1 || rx_dat[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rx_data[0]); end
    checks++; if (first_of(rx_cyc) != t + 33) begin failures++; $display("FAIL single_valid_cyc got=%0d exp=%0d", first_of(rx_cyc), t + 33); end
    checks++; if (first_of(cs_fall) != t + 1 || first_of(busy_rise) != t + 1) begin
      failures++; $display("FAIL single_start_cyc got=%0d/%0d exp=%0d", first_of(cs_fall), first_of(busy_rise), t + 1);
    end
    checks++; if (cs_rise.size() != 1 || first_of(cs_rise) != t + 35) begin failures++; $display("FAIL single_cs_rise got=%0d exp=%0d", first_of(cs_rise), t + 35); end
    checks++; if (done_cyc.size() != 1 || first_of(done_cyc) != t + 37) begin failures++; $display("FAIL single_done got=%0d exp=%0d", first_of(done_cyc), t + 37); end
    checks++; if (mosi_high != 0) begin failures++; $display("FAIL single_mosi_low got=%0d exp=0", mosi_high); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy[0]); end
  endtask

  task automatic test_mosi();
    int t;
    logic [7:0] bits;
    sel = 0; sq.delete(); sq.push_back(8'h3C);
    start_txn(0, 8'd1, 8'hC3, t);
    repeat (45) @(negedge clk);
    #1;
    bits = 8'h00;
    foreach (mosi_seq[i]) bits = {bits[6:0], mosi_seq[i]};
    checks++; if (mosi_seq.size() != 8 || bits !== 8'hC3) begin
      failures++; $display("FAIL mosi_seq got=%h (%0d bits) exp=c3 (8 bits)", bits, mosi_seq.size());
    end
    checks++; if (mosi_unstable != 0) begin failures++; $display("FAIL mosi_stable got=%0d exp=0", mosi_unstable); end
    checks++; if (rx_dat.size() != 1 || rx_dat[0] !== 8'h3C) begin failures++; $display("FAIL mosi_rx got=%h exp=3c", rx_data[0]); end
  endtask

  task automatic test_burst();
    int t;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h04;
    sel = 0; sq.delete();
    for (int i = 0; i < 3; i++) sq.push_back(exp_b[i]);
    start_txn(0, 8'd3, 8'h00, t);
    repeat (110) @(negedge clk);
    #1;
    checks++; if (rx_cyc.size() != 3) begin failures++; $display("FAIL burst_count got=%0d exp=3", rx_cyc.size()); end
    for (int i = 0; i < 3 && i < rx_cyc.size(); i++) begin
      checks++; if (rx_dat[i] !== exp_b[i]) begin failures++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, rx_dat[i], exp_b[i]); end
      checks++; if (rx_cyc[i] != t + 33 + 32 * i) begin failures++; $display("FAIL burst_cyc[%0d] got=%0d exp=%0d", i, rx_cyc[i], t + 33 + 32 * i); end
    end
    checks++; if (cs_fall.size() != 1 || cs_rise.size() != 1 || first_of(cs_rise) != t + 99) begin
      failures++; $display("FAIL burst_cs got=falls%0d rise@%0d exp=falls1 rise@%0d", cs_fall.size(), first_of(cs_rise), t + 99);
    end
    checks++; if (done_cyc.size() != 1 || first_of(done_cyc) != t + 101) begin failures++; $display("FAIL burst_done got=%0d exp=%0d", first_of(done_cyc), t + 101); end
  endtask

  task automatic test_collision();
    int t;
    sel = 0; sq.delete(); sq.push_back(8'h11); sq.push_back(8'h22);
    start_txn(0, 8'd2, 8'h00, t);
    repeat (9) @(negedge clk);
    start[0] = 1'b1;
    num_bytes[0] = 8'd5;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    checks++; if (rx_cyc.size() != 2) begin failures++; $display("FAIL coll_count got=%0d exp=2", rx_cyc.size()); end
    checks++; if (rx_dat.size() != 2 || rx_dat[0] !== 8'h11 || rx_dat[1] !== 8'h22) begin
      failures++; $display("FAIL coll_data got=%h exp=22", rx_data[0]);
    end
    checks++; if (done_cyc.size() != 1 || first_of(done_cyc) != t + 69) begin failures++; $display("FAIL coll_done got=%0d exp=%0d", first_of(done_cyc), t + 69); end
    checks++; if (cs_fall.size() != 1 || busy_rise.size() != 1) begin
      failures++; $display("FAIL coll_restart got=falls%0d busy%0d exp=1/1", cs_fall.size(), busy_rise.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, t2;
    sel = 0; sq.delete(); sq.push_back(8'hA5);
    start_txn(0, 8'd1, 8'h00, t);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (cs[0] !== 1'b1 || sclk[0] !== 1'b0 || mosi[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_pins got=cs%b sclk%b mosi%b exp=cs1 sclk0 mosi0", cs[0], sclk[0], mosi[0]);
    end
    checks++; if (busy[0] !== 1'b0 || rx_valid[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got=%b%b%b exp=000", busy[0], rx_valid[0], done[0]);
    end
    checks++; if (rx_data[0] !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (rx_cyc.size() != 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", rx_cyc.size()); end
    repeat (2) @(negedge clk);
    sq.delete(); sq.push_back(8'h5A);
    start_txn(0, 8'd1, 8'h00, t2);
    repeat (45) @(negedge clk);
    #1;
    checks++; if (rx_dat.size() != 1 || rx_dat[0] !== 8'h5A || first_of(rx_cyc) != t2 + 33) begin
      failures++; $display("FAIL midrst_recover got=%h@%0d exp=5a@%0d", rx_data[0], first_of(rx_cyc), t2 + 33);
    end
    checks++; if (first_of(done_cyc) != t2 + 37) begin failures++; $display("FAIL midrst_done got=%0d exp=%0d", first_of(done_cyc), t2 + 37); end
  endtask

  task automatic test_256_div1();
    int t, bad_data, bad_gap;
    logic [7:0] exp256 [256];
    sel = 1; sq.delete();
    for (int i = 0; i < 256; i++) begin
      exp256[i] = 8'((i * 7 + 3) % 256);
      sq.push_back(exp256[i]);
    end
    start_txn(1, 8'd0, 8'h00, t);
    repeat (16 * 256 + 20) @(negedge clk);
    #1;
    bad_data = 0;
    bad_gap = 0;
    for (int i = 0; i < rx_cyc.size() && i < 256; i++) begin
      if (rx_dat[i] !== exp256[i]) bad_data++;
      if (rx_cyc[i] != t + 17 + 16 * i) bad_gap++;
    end
    checks++; if (rx_cyc.size() != 256) begin failures++; $display("FAIL n256_count got=%0d exp=256", rx_cyc.size()); end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL n256_data got=%0d bad exp=0", bad_data); end
    checks++; if (bad_gap != 0 || first_of(rx_cyc) != t + 17) begin
      failures++; $display("FAIL n256_spacing got=%0d bad first@%0d exp=0 bad first@%0d", bad_gap, first_of(rx_cyc), t + 17);
    end
    checks++; if (cs_rise.size() != 1 || first_of(cs_rise) != t + 4098) begin failures++; $display("FAIL n256_cs_rise got=%0d exp=%0d", first_of(cs_rise), t + 4098); end
    checks++; if (done_cyc.size() != 1 || first_of(done_cyc) != t + 4099) begin failures++; $display("FAIL n256_done got=%0d exp=%0d", first_of(done_cyc), t + 4099); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 2'b00;
    for (int i = 0; i < 2; i++) begin
      num_bytes[i] = 8'h00;
      tx_byte[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_mosi();
    test_burst();
    test_collision();
    test_reset_mid();
    test_256_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_rx.md
# spi_master_rx

SPI mode-0 master that reads bytes from the LFSR SPI slave and forwards them to on-chip logic. It runs on the system clock. From that clock it generates `sclk` and `cs`, shifts a command byte out on `mosi`, samples `miso`, and returns each received byte with a one-cycle valid strobe. It sits between the slave pins and whatever consumes the random bytes, such as a test harness or a data sink.

## Interface
- CLK_DIV, 4: system-clock cycles per `sclk` half-period; legal values are 1 to 255.
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  requests a transaction; accepted only while `busy`=0.
- num_bytes  input  8  bytes in the transaction, sampled when `start` is accepted; 0 means 256.
- tx_byte  input  8  byte driven on `mosi`, MSB first; sampled at `start` and again at each `rx_valid` pulse.
- busy  output  1  high from the cycle after `start` is accepted until the cycle `done` pulses.
- rx_data  output  8  last received byte; holds its value until the next byte.
- rx_valid  output  1  one-cycle pulse when `rx_data` updates.
- done  output  1  one-cycle pulse at the end of the transaction.
- sclk  output  1  SPI clock; idles low.
- cs  output  1  chip select, active low; idles high.
- mosi  output  1  master-out data.
- miso  input  1  slave-out data, already synchronous to `clk` by board design.

## Operation
- The state machine has five states: IDLE, LOW, HIGH, HOLD, GAP.
- **IDLE:** `cs`=1, `sclk`=0, `mosi`=0. A `start` pulse loads the byte counter from `num_bytes` and the TX shift register from `tx_byte`, then moves to LOW.
- **LOW:** `cs`=0, `sclk`=0, `mosi`=TX MSB. The state lasts CLK_DIV cycles, then moves to HIGH.
- **HIGH:** `sclk`=1 for CLK_DIV cycles.
  - On entry to HIGH (the `sclk` rising edge), `miso` is shifted into the RX shift register at the LSB end.
  - On exit from HIGH the TX register shifts left and the bit counter increments.
- **End of bit 0** (8th HIGH exit):
  - `rx_data` gets the RX register and `rx_valid` pulses.
  - The byte counter decrements. If it is nonzero, reload TX from `tx_byte` and go to LOW; otherwise go to HOLD.
- **HOLD:** `cs`=0, `sclk`=0 for CLK_DIV cycles, then go to GAP.
- **GAP:** `cs`=1 for CLK_DIV cycles. Then `done` pulses, `busy` falls and the machine returns to IDLE.
- A `start` pulse while `busy`=1 is ignored with no side effects.
- Counters:
  - Bit counter is 3 bits and wraps 7→0.
  - Byte counter is 8 bits; a load of 0 decrements to 255, which gives 256 bytes.
  - Divider counter is 8 bits and reloads on every state change.
- **Reset (asynchronous, including mid-transfer):** `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `rx_valid`=0, `done`=0, `rx_data`=0, state=IDLE. No partial byte is reported.

## Timing
- Cycle T: `start` is sampled high in IDLE.
- Cycle T+1: `cs`=0, `busy`=1, `sclk`=0, `mosi`=`tx_byte[7]`.
- Bit k (0 = MSB): `sclk` is low over [T+1+2k·CLK_DIV, T+1+(2k+1)·CLK_DIV) and high for the following CLK_DIV cycles.
- `miso` is sampled from the cycle just before `sclk` rises.
- Byte n completes at cycle T+1+16·(n+1)·CLK_DIV; `rx_valid` is high that cycle.
- For an N-byte transaction, with E = T+1+16·N·CLK_DIV:
  - `cs` rises at E+CLK_DIV.
  - `done` pulses and `busy`=0 at E+2·CLK_DIV.
- Example, CLK_DIV=2 and 1 byte: `rx_valid` at T+33, `cs` high at T+35, `done` at T+37.
- The earliest next accepted `start` is at the `done` cycle + 1.

## Structure
- Shared package `spi_pkg`:
  - state enum (IDLE/LOW/HIGH/HOLD/GAP);
  - constants SPI_BITS=8 and SPI_CS_IDLE=1'b1.
- One sub-module, `spi_clk_div`: a CLK_DIV half-period counter with a `tick` output and a `reload` input.
- The FSM, shift registers and byte counter live in `spi_master_rx`.

## Test plan
- **Single read:** CLK_DIV=2, `num_bytes`=1, `tx_byte`=8'h00, slave model drives 8'hA5 → `rx_data`=8'hA5 with `rx_valid` at T+33, `cs` high at T+35, `done` at T+37, `mosi` low throughout.
- **Burst:** `num_bytes`=3, slave returns 8'h01, 8'h02, 8'h04 → three `rx_valid` pulses 32 cycles apart with matching data, `cs` continuously low, and one `done`.
- **MOSI check:** `tx_byte`=8'hC3 held → `mosi` sequence 1,1,0,0,0,0,1,1, with each bit stable through the `sclk` high phase.
- **Busy/start collision:** `start` pulsed at T+10 during a transfer → ignored; byte count and `done` timing are unchanged.
- **Reset mid-byte:** `rst_n` low at T+12 → same cycle, `cs`=1, `sclk`=0, `busy`=0, no `rx_valid`. A subsequent `start` completes normally.
- **num_bytes=0, CLK_DIV=1:** → exactly 256 `rx_valid` pulses, 16 cycles apart, then `done`.
